mfp_srec_dumper: RTL
====================

// Module: mfp_srec_dumper
// PURPOSE
//  AHB-Lite read master that dumps a memory range as Motorola S-record text: S3 data records then an S7 terminator.
//  Produces an ASCII byte stream with valid/ready for the UART transmitter (mfp_uart_transmitter).
//  Sits beside the SREC loader path and gets the bus only while busy. Allows host-side readback and compare of loaded images.
// PARAMETERS
//  WORDS_PER_RECORD  4   32-bit words per S3 record (1..8); record data bytes = 4*WORDS_PER_RECORD
// PORTS
//  clock          in   1   system clock (HCLK domain)
//  reset          in   1   synchronous, active-high reset
//  big_endian     in   1   1: byte addr+0 = HRDATA[31:24]; 0: byte addr+0 = HRDATA[7:0]
//  start          in   1   one-cycle request; sampled only when busy=0
//  start_address  in   32  first word address; bits [1:0] are ignored (forced 0)
//  word_count     in   16  number of words to dump; 0 = terminator only
//  busy           out  1   dump in progress
//  done           out  1   one-cycle pulse when the final LF is accepted
//  read_error     out  1   sticky HRESP=1 seen; cleared on accepted start
//  HADDR          out  32  word address
//  HTRANS         out  2   IDLE/NONSEQ only
//  HSIZE          out  3   fixed 3'b010
//  HBURST         out  3   fixed SINGLE
//  HPROT          out  4   fixed 4'b0011
//  HMASTLOCK, HWRITE  out  1   fixed 0
//  HWDATA         out  32  fixed 0
//  HRDATA         in   32  read data
//  HREADY         in   1   transfer ready
//  HRESP          in   1   error response
//  char_data      out  8   ASCII byte
//  char_valid     out  1   char_data valid; held with stable data until char_ready
//  char_ready     in   1   transmitter accepts the byte in any cycle where valid&ready
// BEHAVIOUR
//  Reset: busy=done=read_error=char_valid=0; HTRANS=IDLE; HADDR=0; char_data=0; state IDLE. Reset mid-dump aborts at once.
//  FSM: IDLE -> RD_ADDR -> RD_DATA -> (loop per word) -> EMIT_REC -> (RD_ADDR | EMIT_TERM) -> IDLE.
//  IDLE: start latches address/count and sets busy next cycle; RD_ADDR follows in the cycle after start.
//  RD_ADDR: drive NONSEQ + HADDR only while HREADY=1 (one-cycle address phase), then HTRANS=IDLE.
//  RD_DATA: wait for HREADY=1, capture HRDATA into a word buffer, OR HRESP into read_error. Data is used even on error.
//  A record holds min(WORDS_PER_RECORD, remaining) words. All reads complete before any character of that record.
//  EMIT_REC: "S3", count, addr8, data, checksum, CR(0x0D), LF(0x0A). Hex is uppercase, 2 chars per byte, high nibble first.
//   Record count = 5 + data bytes. Checksum = ~(count + 4 address bytes + data bytes) mod 256.
//   Data bytes are emitted in ascending address order, selected per big_endian.
//  Record address increments by 4*words in the record. It wraps modulo 2^32; 0xFFFFFFFC+4 -> 0x00000000.
//  EMIT_TERM: "S705" + start_address (8 hex) + checksum + CR LF.
//  done pulses in the cycle after the final LF handshake; busy=0 in that same cycle.
//  start while busy is ignored. No character is dropped or repeated under any char_ready pattern.
//  Word-count arithmetic is 16-bit. The last record is partial when word_count is not a multiple of WORDS_PER_RECORD.
// STRUCTURE
//  Shared mfp_ahb_lite.vh: HTRANS_IDLE/NONSEQ, HSIZE_32, HBURST_SINGLE encodings.
//  Local constants: ASCII_S, ASCII_CR, ASCII_LF.
//  Sub-module mfp_hex_byte_serializer: byte in with valid/ready, two uppercase ASCII hex chars out with valid/ready.
//  Literal characters bypass the serializer through a 2:1 output mux.
// TESTING
//  1. LE, mem[0]=0x11223344, start_address=0, word_count=1
//     -> "S30900000000443322114C\r\n" then "S70500000000FA\r\n", one done pulse.
//  2. Same as test 1 with big_endian=1 -> "S30900000000112233444C\r\n", then the same S7 line.
//  3. word_count=0, start_address=0 -> only "S70500000000FA\r\n". No AHB NONSEQ is issued.
//  4. word_count=5 at 0x00001000 -> record 1 count 0x15 at 00001000; record 2 count 0x09 at 00001010.
//     Checksums match a reference model.
//  5. HREADY low 3 cycles per data phase and char_ready random 30% -> identical text.
//     HADDR is held while HREADY=0; no duplicate or lost characters.
//  6. reset asserted mid-data-emission -> next cycle char_valid=0, HTRANS=IDLE, busy=0.
//     A new start then gives a correct full dump. HRESP=1 on one word sets read_error; start clears it.

Source files
------------

// File: rtl/mfp_srec_dumper_pkg.sv
// Shared encodings and helpers for the S-record dump master.
package mfp_srec_dumper_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_EMIT_REC,
    ST_EMIT_TERM
  } state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_32      = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [3:0] HPROT_DATA    = 4'b0011;

  localparam logic [7:0] ASCII_S  = 8'h53;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  localparam int unsigned MAX_WORDS = 8;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

endpackage

// File: rtl/mfp_hex_byte_serializer.sv
// Turns one byte into two uppercase ASCII hex characters, high nibble first.
module mfp_hex_byte_serializer
  import mfp_srec_dumper_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] byte_data,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic [7:0] char_data,
  output logic       char_valid,
  input  logic       char_ready,
  output logic       char_last
);

  logic [3:0] lo_nibble;

  assign byte_ready = !char_valid;

  always_ff @(posedge clock) begin
    if (reset) begin
      char_data  <= '0;
      char_valid <= 1'b0;
      char_last  <= 1'b0;
      lo_nibble  <= '0;
    end else if (byte_valid && byte_ready) begin
      char_data  <= hex_ascii(byte_data[7:4]);
      lo_nibble  <= byte_data[3:0];
      char_valid <= 1'b1;
      char_last  <= 1'b0;
    end else if (char_valid && char_ready) begin
      if (!char_last) begin
        char_data <= hex_ascii(lo_nibble);
        char_last <= 1'b1;
      end else begin
        char_valid <= 1'b0;
        char_last  <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/mfp_srec_dumper.sv
// AHB-Lite read master dumping a word range as S3 records plus an S7 terminator.
module mfp_srec_dumper
  import mfp_srec_dumper_pkg::*;
#(
  parameter int unsigned WORDS_PER_RECORD = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        big_endian,
  input  logic        start,
  input  logic [31:0] start_address,
  input  logic [15:0] word_count,
  output logic        busy,
  output logic        done,
  output logic        read_error,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic        HMASTLOCK,
  output logic        HWRITE,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP,
  output logic [7:0]  char_data,
  output logic        char_valid,
  input  logic        char_ready
);

  localparam logic [15:0] WPR16 = 16'(WORDS_PER_RECORD);

  function automatic logic [3:0] min_words(input logic [15:0] r);
    return (r < WPR16) ? r[3:0] : WPR16[3:0];
  endfunction

  state_t      state;
  logic [31:0] base_addr, rec_addr, rec_next;
  logic [15:0] rem;
  logic [3:0]  rec_words, wcnt, next_words;
  logic [31:0] wbuf [MAX_WORDS];
  logic [7:0]  item, sum, nbytes;
  logic        pending, pend_last, sel_hex, lit_valid;
  logic [7:0]  lit_data;

  logic        emit_term, emit_active, issue, item_done;
  logic [31:0] emit_addr, data_word;
  logic [4:0]  data_off;
  logic [1:0]  lane;
  logic        cur_hex, cur_sum, cur_last;
  logic [7:0]  cur_byte, cur_lit, data_byte;
  logic        ser_byte_ready, ser_valid, ser_last;
  logic [7:0]  ser_data;

  assign HSIZE     = HSIZE_32;
  assign HBURST    = HBURST_SINGLE;
  assign HPROT     = HPROT_DATA;
  assign HMASTLOCK = 1'b0;
  assign HWRITE    = 1'b0;
  assign HWDATA    = '0;

  assign emit_term   = (state == ST_EMIT_TERM);
  assign emit_active = (state == ST_EMIT_REC) || emit_term;
  assign nbytes      = emit_term ? 8'd0 : {2'b00, rec_words, 2'b00};
  assign emit_addr   = emit_term ? base_addr : rec_addr;
  assign rec_next    = rec_addr + {26'd0, rec_words, 2'b00};
  assign next_words  = min_words(rem);

  // Data items start at item 7; lane is flipped so ascending addresses come out first.
  assign data_off  = 5'(item - 8'd7);
  assign data_word = wbuf[data_off[4:2]];
  assign lane      = big_endian ? ~data_off[1:0] : data_off[1:0];
  assign data_byte = data_word[{lane, 3'b000} +: 8];

  always_comb begin
    cur_hex  = 1'b0;
    cur_sum  = 1'b0;
    cur_last = 1'b0;
    cur_byte = '0;
    cur_lit  = '0;
    if (item == 8'd0) begin
      cur_lit = ASCII_S;
    end else if (item == 8'd1) begin
      cur_lit = emit_term ? 8'h37 : 8'h33;
    end else if (item == 8'd2) begin
      cur_hex  = 1'b1;
      cur_sum  = 1'b1;
      cur_byte = 8'd5 + nbytes;
    end else if (item < 8'd7) begin
      cur_hex = 1'b1;
      cur_sum = 1'b1;
      case (item[2:0])
        3'd3:    cur_byte = emit_addr[31:24];
        3'd4:    cur_byte = emit_addr[23:16];
        3'd5:    cur_byte = emit_addr[15:8];
        default: cur_byte = emit_addr[7:0];
      endcase
    end else if (item < 8'd7 + nbytes) begin
      cur_hex  = 1'b1;
      cur_sum  = 1'b1;
      cur_byte = data_byte;
    end else if (item == 8'd7 + nbytes) begin
      cur_hex  = 1'b1;
      cur_byte = ~sum;
    end else if (item == 8'd8 + nbytes) begin
      cur_lit = ASCII_CR;
    end else begin
      cur_lit  = ASCII_LF;
      cur_last = 1'b1;
    end
  end

  assign issue     = emit_active && !pending && (!cur_hex || ser_byte_ready);
  assign item_done = pending && char_ready &&
                     (sel_hex ? (ser_valid && ser_last) : lit_valid);

  assign char_valid = sel_hex ? ser_valid : lit_valid;
  assign char_data  = sel_hex ? ser_data  : lit_data;

  mfp_hex_byte_serializer u_hex (
    .clock      (clock),
    .reset      (reset),
    .byte_data  (cur_byte),
    .byte_valid (issue && cur_hex),
    .byte_ready (ser_byte_ready),
    .char_data  (ser_data),
    .char_valid (ser_valid),
    .char_ready (char_ready),
    .char_last  (ser_last)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      read_error <= 1'b0;
      HTRANS     <= HTRANS_IDLE;
      HADDR      <= '0;
      base_addr  <= '0;
      rec_addr   <= '0;
      rem        <= '0;
      rec_words  <= '0;
      wcnt       <= '0;
      item       <= '0;
      sum        <= '0;
      pending    <= 1'b0;
      pend_last  <= 1'b0;
      sel_hex    <= 1'b0;
      lit_valid  <= 1'b0;
      lit_data   <= '0;
    end else begin
      done <= 1'b0;
      if (lit_valid && char_ready) lit_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            base_addr  <= start_address & 32'hFFFF_FFFC;
            rec_addr   <= start_address & 32'hFFFF_FFFC;
            rec_words  <= min_words(word_count);
            rem        <= word_count - {12'd0, min_words(word_count)};
            wcnt       <= '0;
            item       <= '0;
            sum        <= '0;
            busy       <= 1'b1;
            read_error <= 1'b0;
            if (word_count == 16'd0) begin
              state <= ST_EMIT_TERM;
            end else begin
              state  <= ST_RD_ADDR;
              HTRANS <= HTRANS_NONSEQ;
              HADDR  <= start_address & 32'hFFFF_FFFC;
            end
          end
        end
        ST_RD_ADDR: begin
          if (HREADY) begin
            HTRANS <= HTRANS_IDLE;
            state  <= ST_RD_DATA;
          end
        end
        ST_RD_DATA: begin
          if (HREADY) begin
            wbuf[wcnt[2:0]] <= HRDATA;
            read_error      <= read_error | HRESP;
            if (wcnt + 4'd1 == rec_words) begin
              state <= ST_EMIT_REC;
              item  <= '0;
              sum   <= '0;
            end else begin
              wcnt   <= wcnt + 4'd1;
              HADDR  <= HADDR + 32'd4;
              HTRANS <= HTRANS_NONSEQ;
              state  <= ST_RD_ADDR;
            end
          end
        end
        default: begin
          // Each item (literal or hex pair) is fully handed off before the next is staged.
          if (issue) begin
            pending   <= 1'b1;
            pend_last <= cur_last;
            item      <= item + 8'd1;
            sel_hex   <= cur_hex;
            if (cur_sum) sum <= sum + cur_byte;
            if (!cur_hex) begin
              lit_valid <= 1'b1;
              lit_data  <= cur_lit;
            end
          end else if (item_done) begin
            pending <= 1'b0;
            if (pend_last) begin
              if (emit_term) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                rec_addr <= rec_next;
                item     <= '0;
                sum      <= '0;
                if (rem == 16'd0) begin
                  state <= ST_EMIT_TERM;
                end else begin
                  rec_words <= next_words;
                  rem       <= rem - {12'd0, next_words};
                  wcnt      <= '0;
                  HADDR     <= rec_next;
                  HTRANS    <= HTRANS_NONSEQ;
                  state     <= ST_RD_ADDR;
                end
              end
            end
          end
        end
      endcase
    end
  end

endmodule
